multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath handshake and control bundle for the
// multicycle controller. The master side drives run/opcode/flags/mem_ready,
// and the slave side (the controller) drives pc, strobes and datapath controls.
interface multicycle_ctrl_if;
  logic        run;
  logic [1:0]  opcode;
  logic        zero;
  logic [15:0] imm;
  logic        mem_ready;
  logic [15:0] pc;
  logic        ir_load;
  logic        RegDst;
  logic        AluSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  AluOp;
  logic [2:0]  state;
  logic        instr_done;
  logic [15:0] instr_count;

  modport master (
    output run, opcode, zero, imm, mem_ready,
    input  pc, ir_load, RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite,
    input  AluOp, state, instr_done, instr_count
  );

  modport slave (
    input  run, opcode, zero, imm, mem_ready,
    output pc, ir_load, RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite,
    output AluOp, state, instr_done, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for a small
// multicycle datapath, with program counter and retired-instruction counter.
// Optional feature macro: MC_BRANCH_EN -- when defined, BEQ takes the branch
// (pc += imm) on zero=1; when undefined, opcode 11 retires as a NOP.
// Datapath controls, state, pc, count and instr_done are all registers.
// ir_load is the one exception: it marks the FETCH cycle in which memory
// answers, so it is the registered FETCH state qualified by mem_ready.
module multicycle_ctrl #(
  parameter logic [15:0] PC_RESET = 16'd10,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } stateT;

  typedef struct packed {
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] aluOp;
  } ctrlT;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;
  localparam ctrlT       CTRL_OFF = ctrlT'(8'h00);

  stateT       state_r, stateNext_s;
  logic [1:0]  op_r, opNext_s;
  logic [15:0] pc_r, pcNext_s;
  logic [15:0] count_r, countNext_s;
  logic        retire_s;
  logic        irLoad_s;
  logic        done_r;
  ctrlT        ctrl_r;

`ifndef MC_BRANCH_EN
  // Branch operands only matter when branches are built in.
  logic unusedBranch_s;
  assign unusedBranch_s = ^{bus.zero, bus.imm};
`endif

  // Control values that belong to a given state and latched opcode.
  function automatic ctrlT decodeCtrl(input stateT s, input logic [1:0] op);
    ctrlT c;
    c = CTRL_OFF;
    case (s)
      FETCH: c.memRead = 1'b1;
      EXEC: begin
        case (op)
          OP_R:         c.aluOp = 2'b10;
          OP_LW, OP_SW: c.aluSrc = 1'b1;
`ifdef MC_BRANCH_EN
          OP_BEQ:       c.aluOp = 2'b01;
`else
          OP_BEQ:       c = CTRL_OFF;
`endif
          default:      c = CTRL_OFF;
        endcase
      end
      MEM: begin
        if (op == OP_LW) begin
          c.memRead = 1'b1;
        end else if (op == OP_SW) begin
          c.memWrite = 1'b1;
        end else begin
          c = CTRL_OFF;
        end
      end
      WB: begin
        c.regWrite = 1'b1;
        if (op == OP_R) begin
          c.regDst = 1'b1;
        end else begin
          c.memToReg = 1'b1;
        end
      end
      default: c = CTRL_OFF;
    endcase
    return c;
  endfunction

  // Next state, opcode latch, pc and retire decisions.
  always_comb begin
    stateNext_s = state_r;
    opNext_s    = op_r;
    pcNext_s    = pc_r;
    countNext_s = count_r;
    retire_s    = 1'b0;
    irLoad_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.run) begin
          stateNext_s = FETCH;
        end else begin
          stateNext_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.mem_ready) begin
          irLoad_s    = 1'b1;
          pcNext_s    = pc_r + PC_STEP;
          stateNext_s = DECODE;
        end else begin
          stateNext_s = FETCH;
        end
      end
      DECODE: begin
        opNext_s    = bus.opcode;
        stateNext_s = EXEC;
      end
      EXEC: begin
        case (op_r)
          OP_R:         stateNext_s = WB;
          OP_LW, OP_SW: stateNext_s = MEM;
          OP_BEQ: begin
`ifdef MC_BRANCH_EN
            if (bus.zero) begin
              pcNext_s = pc_r + bus.imm;
            end else begin
              pcNext_s = pc_r;
            end
`endif
            retire_s = 1'b1;
          end
          default: stateNext_s = IDLE;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (op_r == OP_LW) begin
            stateNext_s = WB;
          end else begin
            retire_s = 1'b1;
          end
        end else begin
          stateNext_s = MEM;
        end
      end
      WB: retire_s = 1'b1;
      default: stateNext_s = IDLE;
    endcase
    // A retiring instruction bumps the counter and either continues or parks.
    if (retire_s) begin
      countNext_s = count_r + 16'd1;
      if (bus.run) begin
        stateNext_s = FETCH;
      end else begin
        stateNext_s = IDLE;
      end
    end else begin
      countNext_s = count_r;
    end
  end

  // State, pc, counter and registered controls; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= OP_R;
      pc_r    <= PC_RESET;
      count_r <= 16'd0;
      done_r  <= 1'b0;
      ctrl_r  <= CTRL_OFF;
    end else begin
      state_r <= stateNext_s;
      op_r    <= opNext_s;
      pc_r    <= pcNext_s;
      count_r <= countNext_s;
      done_r  <= retire_s;
      ctrl_r  <= decodeCtrl(stateNext_s, opNext_s);
    end
  end

  assign bus.state       = state_r;
  assign bus.pc          = pc_r;
  assign bus.instr_count = count_r;
  assign bus.instr_done  = done_r;
  assign bus.ir_load     = irLoad_s;
  assign bus.RegDst      = ctrl_r.regDst;
  assign bus.AluSrc      = ctrl_r.aluSrc;
  assign bus.MemToReg    = ctrl_r.memToReg;
  assign bus.RegWrite    = ctrl_r.regWrite;
  assign bus.MemRead     = ctrl_r.memRead;
  assign bus.MemWrite    = ctrl_r.memWrite;
  assign bus.AluOp       = ctrl_r.aluOp;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized bench for multicycle_ctrl. An instruction-level
// model expands each planned instruction (opcode, memory wait counts, branch
// operands, whether run stays high at retire) into the cycles the controller
// must walk through, and checks state, controls, pc, count and retire pulse.
module tb_multicycle_ctrl;
  localparam logic [15:0] PC_RESET = 16'd10;
  localparam logic [15:0] PC_STEP  = 16'd2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  // Control vector {RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, AluOp}
  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_MEMRD = 8'h08;
  localparam logic [7:0] C_MEMWR = 8'h04;
  localparam logic [7:0] C_EXR   = 8'h02;
  localparam logic [7:0] C_EXLS  = 8'h40;
  localparam logic [7:0] C_WBR   = 8'h90;
  localparam logic [7:0] C_WBLW  = 8'h30;
`ifdef MC_BRANCH_EN
  localparam logic [7:0] C_EXBEQ = 8'h01;
`else
  localparam logic [7:0] C_EXBEQ = 8'h00;
`endif

  logic clk;
  logic reset;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.PC_RESET(PC_RESET), .PC_STEP(PC_STEP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int          total;
  int          bad;
  logic [15:0] mPc;
  logic [15:0] mCount;
  logic        mDone;
  logic [7:0]  ctrlObs;

  assign ctrlObs = {bus.RegDst, bus.AluSrc, bus.MemToReg, bus.RegWrite,
                    bus.MemRead, bus.MemWrite, bus.AluOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [15:0] rim();
    return 16'($urandom);
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic step(input logic r, input logic mr, input logic [1:0] op, input logic z,
                      input logic [15:0] im, input logic [2:0] eState, input logic [7:0] eCtrl,
                      input logic eIr, input logic retires);
    bus.run       = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = z;
    bus.imm       = im;
    @(negedge clk);
    checkEq("state", 16'(bus.state), 16'(eState));
    checkEq("ctrl", 16'(ctrlObs), 16'(eCtrl));
    checkEq("ir_load", 16'(bus.ir_load), 16'(eIr));
    checkEq("pc", bus.pc, mPc);
    checkEq("count", bus.instr_count, mCount);
    checkEq("instr_done", 16'(bus.instr_done), 16'(mDone));
    @(posedge clk);
    #1;
    mDone = retires;
    if (retires) mCount = mCount + 16'd1;
  endtask

  // One whole instruction, starting in FETCH; run only matters at retire.
  task automatic runInstr(input logic [1:0] op, input int wf, input int wm, input logic z,
                          input logic [15:0] im, input logic runEnd);
    logic [7:0] memC;
    for (int i = 0; i < wf; i++) step(rb(), 1'b0, rop(), rb(), rim(), S_FETCH, C_MEMRD, 1'b0, 1'b0);
    step(rb(), 1'b1, rop(), rb(), rim(), S_FETCH, C_MEMRD, 1'b1, 1'b0);
    mPc = mPc + PC_STEP;
    step(rb(), rb(), op, rb(), rim(), S_DECODE, C_NONE, 1'b0, 1'b0);
    if (op == OP_BEQ) begin
      step(runEnd, rb(), rop(), z, im, S_EXEC, C_EXBEQ, 1'b0, 1'b1);
`ifdef MC_BRANCH_EN
      if (z) mPc = mPc + im;
`endif
    end else begin
      step(rb(), rb(), rop(), z, im, S_EXEC, (op == OP_R) ? C_EXR : C_EXLS, 1'b0, 1'b0);
      if (op != OP_R) begin
        memC = (op == OP_LW) ? C_MEMRD : C_MEMWR;
        for (int i = 0; i < wm; i++) step(rb(), 1'b0, rop(), rb(), rim(), S_MEM, memC, 1'b0, 1'b0);
        step((op == OP_SW) ? runEnd : rb(), 1'b1, rop(), rb(), rim(), S_MEM, memC, 1'b0, op == OP_SW);
      end
      if (op != OP_SW) step(runEnd, rb(), rop(), rb(), rim(), S_WB, (op == OP_R) ? C_WBR : C_WBLW, 1'b0, 1'b1);
    end
  endtask

  // Sit in IDLE for n cycles with run low, then raise run to resume fetching.
  task automatic idleResume(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rb(), rop(), rb(), rim(), S_IDLE, C_NONE, 1'b0, 1'b0);
    step(1'b1, rb(), rop(), rb(), rim(), S_IDLE, C_NONE, 1'b0, 1'b0);
  endtask

  // Assert reset now (asynchronously), check the forced values, release, resume.
  task automatic applyReset();
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    reset         = 1'b1;
    #1;
    checkEq("rst_state", 16'(bus.state), 16'(S_IDLE));
    checkEq("rst_pc", bus.pc, PC_RESET);
    checkEq("rst_count", bus.instr_count, 16'd0);
    checkEq("rst_ctrl", 16'(ctrlObs), 16'(C_NONE));
    checkEq("rst_done", 16'(bus.instr_done), 16'd0);
    checkEq("rst_ir_load", 16'(bus.ir_load), 16'd0);
    @(posedge clk);
    #1;
    checkEq("rst_hold_state", 16'(bus.state), 16'(S_IDLE));
    checkEq("rst_hold_done", 16'(bus.instr_done), 16'd0);
    reset  = 1'b0;
    mPc    = PC_RESET;
    mCount = 16'd0;
    mDone  = 1'b0;
    step(1'b1, rb(), rop(), rb(), rim(), S_IDLE, C_NONE, 1'b0, 1'b0);
  endtask

  initial begin
    logic        runEnd;
    logic [1:0]  op;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 2'b00;
    bus.zero      = 1'b0;
    bus.imm       = 16'd0;
    @(posedge clk);
    #1;
    applyReset();

    // Back-to-back R-type with memory always ready: pc 10, 12, 14 in FETCH.
    for (int i = 0; i < 3; i++) runInstr(OP_R, 0, 0, rb(), rim(), 1'b1);

    // Branch from pc 10: taken then not-taken, then LW with stalls, then SW.
    applyReset();
    runInstr(OP_BEQ, 0, 0, 1'b1, 16'hFFF8, 1'b1);
    runInstr(OP_BEQ, 0, 0, 1'b0, 16'hFFF8, 1'b1);
    runInstr(OP_LW, 0, 3, rb(), rim(), 1'b1);
    runInstr(OP_SW, 1, 2, rb(), rim(), 1'b1);

    // Random instruction mix, random stalls, occasional pauses in IDLE.
    for (int n = 0; n < 60; n++) begin
      op     = rop();
      runEnd = ($urandom_range(0, 3) != 0);
      runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(), rim(), runEnd);
      if (!runEnd) idleResume($urandom_range(0, 2));
    end

    // Reset while an SW waits in MEM: the write strobe must drop at once.
    step(rb(), 1'b1, rop(), rb(), rim(), S_FETCH, C_MEMRD, 1'b1, 1'b0);
    mPc = mPc + PC_STEP;
    step(rb(), rb(), OP_SW, rb(), rim(), S_DECODE, C_NONE, 1'b0, 1'b0);
    step(rb(), rb(), rop(), rb(), rim(), S_EXEC, C_EXLS, 1'b0, 1'b0);
    step(rb(), 1'b0, rop(), rb(), rim(), S_MEM, C_MEMWR, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    #2;
    checkEq("sw_wait_state", 16'(bus.state), 16'(S_MEM));
    checkEq("sw_wait_memwrite", 16'(bus.MemWrite), 16'd1);
    applyReset();

    // Counter wrap: preload all-ones, retire one with run low, park in IDLE.
    force dut.count_r = 16'hFFFF;
    #1;
    release dut.count_r;
    mCount = 16'hFFFF;
    runInstr(OP_R, 0, 0, rb(), rim(), 1'b0);
    idleResume(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
